mosquito_hit_detector: RTL and testbench

//  Downstream consumer of mosquito_motion_controller positions. Owns a single player bullet:

---
 rtl/mosquito_pkg.sv | 19 +
 rtl/mosquito_hit_detector_if.sv | 34 +++
 rtl/mosquito_hit_detector_bcd.sv | 43 ++++
 rtl/mosquito_hit_detector.sv | 153 +++++++++++++++
 tb/tb_mosquito_hit_detector.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mosquito_pkg.sv
// rtl/mosquito_pkg.sv - shared geometry constants and FSM state type for the mosquito game
//   COORD_W   : coordinate width in pixels
//   SCREEN_W/H: visible raster size
//   MOSQ_SIZE : square mosquito hitbox edge, origin at top-left
//   hit_state_e: bullet FSM states (IDLE=0, FLY=1, SCAN=2)
package mosquito_pkg;

  localparam int COORD_W   = 10;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int MOSQ_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    SCAN = 2'd2
  } hit_state_e;

endpackage

// File: rtl/mosquito_hit_detector_if.sv
// rtl/mosquito_hit_detector_if.sv - bus between the motion stage/player input and the hit detector
//   fire, player_x, mosquito_*_flat : game inputs (driven by master)
//   bullet_x/y, bullet_active       : bullet state for the renderer (driven by slave)
//   kill_flat, hit_pulse            : one-cycle kill strobes
//   score_bcd                       : packed BCD score, digit 0 in LSBs
interface mosquito_hit_detector_if #(
  parameter int N_MOSQ       = 2,
  parameter int SCORE_DIGITS = 4
);
  import mosquito_pkg::*;

  logic                         fire;
  logic [COORD_W-1:0]           player_x;
  logic [COORD_W*N_MOSQ-1:0]    mosquito_x_flat;
  logic [COORD_W*N_MOSQ-1:0]    mosquito_y_flat;
  logic [N_MOSQ-1:0]            mosquito_alive_flat;
  logic [COORD_W-1:0]           bullet_x;
  logic [COORD_W-1:0]           bullet_y;
  logic                         bullet_active;
  logic [N_MOSQ-1:0]            kill_flat;
  logic                         hit_pulse;
  logic [4*SCORE_DIGITS-1:0]    score_bcd;

  modport master (
    output fire, player_x, mosquito_x_flat, mosquito_y_flat, mosquito_alive_flat,
    input  bullet_x, bullet_y, bullet_active, kill_flat, hit_pulse, score_bcd
  );

  modport slave (
    input  fire, player_x, mosquito_x_flat, mosquito_y_flat, mosquito_alive_flat,
    output bullet_x, bullet_y, bullet_active, kill_flat, hit_pulse, score_bcd
  );

endinterface

// File: rtl/mosquito_hit_detector_bcd.sv
// rtl/mosquito_hit_detector_bcd.sv - saturating packed-BCD score counter
//   clk25     : pixel clock
//   reset_n   : async active-low reset, clears score
//   inc       : add one this cycle
//   score_bcd : packed BCD, digit 0 in LSBs; holds at all-9s
module bcd_score_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk25,
  input  logic                  reset_n,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   score_bcd
);

  logic [4*DIGITS-1:0] score_nxt;
  logic                carry;

  // Ripple the +1 through the digits; a carry out of the top digit means
  // every digit was 9, which is the saturation condition.
  always_comb begin
    score_nxt = score_bcd;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (score_bcd[4*d +: 4] == 4'd9) begin
          score_nxt[4*d +: 4] = 4'd0;
        end else begin
          score_nxt[4*d +: 4] = score_bcd[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd <= '0;
    end else if (inc && !carry) begin
      score_bcd <= score_nxt;
    end
  end

endmodule

// File: rtl/mosquito_hit_detector.sv
// rtl/mosquito_hit_detector.sv - single player bullet: launch, upward motion, mosquito hit scan, score
//   clk25   : 25 MHz pixel clock
//   reset_n : async active-low reset
//   bus     : mosquito_hit_detector_if.slave (fire/player/mosquito inputs; bullet, kill, score outputs)
//   AUTO_FIRE_EN : when defined, a held fire level launches from IDLE instead of only a rising edge
module mosquito_hit_detector
  import mosquito_pkg::*;
#(
  parameter int N_MOSQ       = 2,
  parameter int BULLET_Y0    = 440,
  parameter int BULLET_STEP  = 4,
  parameter int TICK_DIV     = 32768,
  parameter int SCORE_DIGITS = 4
) (
  input  logic                     clk25,
  input  logic                     reset_n,
  mosquito_hit_detector_if.slave   bus
);

  localparam int IDX_W = (N_MOSQ > 1) ? $clog2(N_MOSQ) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [COORD_W:0] SIZE_W = (COORD_W+1)'(MOSQ_SIZE);

  hit_state_e          state_q, state_d;
  logic                fire_q;
  logic [CNT_W-1:0]    tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [COORD_W-1:0]  bx_q, bx_d, by_q, by_d;
  logic                act_q, act_d;
  logic [N_MOSQ-1:0]   kill_q, kill_d;
  logic                hit_q, hit_d;
  logic                score_inc, launch, tick_wrap, slot_hit;
  logic [COORD_W-1:0]  mx_arr [N_MOSQ];
  logic [COORD_W-1:0]  my_arr [N_MOSQ];
  logic [COORD_W:0]    mx_w, my_w, bx_w, by_w;

  always_comb begin
    for (int i = 0; i < N_MOSQ; i++) begin
      mx_arr[i] = bus.mosquito_x_flat[i*COORD_W +: COORD_W];
      my_arr[i] = bus.mosquito_y_flat[i*COORD_W +: COORD_W];
    end
  end

  // One extra bit so mx+MOSQ_SIZE near the top of the coordinate range
  // cannot wrap and produce a false miss.
  always_comb begin
    mx_w     = {1'b0, mx_arr[idx_q]};
    my_w     = {1'b0, my_arr[idx_q]};
    bx_w     = {1'b0, bx_q};
    by_w     = {1'b0, by_q};
    slot_hit = bus.mosquito_alive_flat[idx_q]
             && (mx_w <= bx_w) && (bx_w < mx_w + SIZE_W)
             && (my_w <= by_w) && (by_w < my_w + SIZE_W);
  end

`ifdef AUTO_FIRE_EN
  assign launch = bus.fire;
`else
  assign launch = bus.fire & ~fire_q;
`endif

  assign tick_wrap = (tick_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    bx_d      = bx_q;
    by_d      = by_q;
    act_d     = act_q;
    kill_d    = '0;
    hit_d     = 1'b0;
    score_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          bx_d    = bus.player_x;
          by_d    = COORD_W'(BULLET_Y0);
          act_d   = 1'b1;
          tick_d  = '0;
          state_d = FLY;
        end
      end
      FLY: begin
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (tick_wrap) begin
          if (by_q < COORD_W'(BULLET_STEP)) begin
            act_d   = 1'b0;
            state_d = IDLE;
          end else begin
            by_d    = by_q - COORD_W'(BULLET_STEP);
            idx_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // The tick keeps running so the move period stays TICK_DIV cycles.
        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        if (slot_hit) begin
          kill_d[idx_q] = 1'b1;
          hit_d         = 1'b1;
          act_d         = 1'b0;
          score_inc     = 1'b1;
          state_d       = IDLE;
        end else if (idx_q == IDX_W'(N_MOSQ - 1)) begin
          state_d = FLY;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
      tick_q  <= '0;
      idx_q   <= '0;
      bx_q    <= '0;
      by_q    <= COORD_W'(BULLET_Y0);
      act_q   <= 1'b0;
      kill_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= bus.fire;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      act_q   <= act_d;
      kill_q  <= kill_d;
      hit_q   <= hit_d;
    end
  end

  bcd_score_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk25     (clk25),
    .reset_n   (reset_n),
    .inc       (score_inc),
    .score_bcd (bus.score_bcd)
  );

  assign bus.bullet_x      = bx_q;
  assign bus.bullet_y      = by_q;
  assign bus.bullet_active = act_q;
  assign bus.kill_flat     = kill_q;
  assign bus.hit_pulse     = hit_q;

endmodule

// File: tb/tb_mosquito_hit_detector.sv
// tb/tb_mosquito_hit_detector.sv - randomized self-checking bench with an arithmetic flight model
module tb_mosquito_hit_detector;
  import mosquito_pkg::*;

  localparam int TICK = 8;
  localparam int Y0   = 440;
  localparam int STEP = 4;
`ifdef AUTO_FIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk25 = 1'b0;
  logic reset_n;
  always #20 clk25 = ~clk25;

  mosquito_hit_detector_if #(.N_MOSQ(2), .SCORE_DIGITS(4)) bus ();
  mosquito_hit_detector_if #(.N_MOSQ(2), .SCORE_DIGITS(2)) bus2 ();

  assign bus2.fire                = bus.fire;
  assign bus2.player_x            = bus.player_x;
  assign bus2.mosquito_x_flat     = bus.mosquito_x_flat;
  assign bus2.mosquito_y_flat     = bus.mosquito_y_flat;
  assign bus2.mosquito_alive_flat = bus.mosquito_alive_flat;

  mosquito_hit_detector #(.N_MOSQ(2), .BULLET_Y0(Y0), .BULLET_STEP(STEP),
                          .TICK_DIV(TICK), .SCORE_DIGITS(4)) dut (
    .clk25 (clk25), .reset_n (reset_n), .bus (bus));

  mosquito_hit_detector #(.N_MOSQ(2), .BULLET_Y0(Y0), .BULLET_STEP(STEP),
                          .TICK_DIV(TICK), .SCORE_DIGITS(2)) dut_sat (
    .clk25 (clk25), .reset_n (reset_n), .bus (bus2));

  int checks = 0;
  int errors = 0;
  int hits_total = 0;

  function automatic logic [15:0] to_bcd4(input int v);
    int t;
    logic [15:0] r;
    t = (v > 9999) ? 9999 : v;
    r[3:0]   = 4'(t % 10);
    r[7:4]   = 4'((t / 10) % 10);
    r[11:8]  = 4'((t / 100) % 10);
    r[15:12] = 4'((t / 1000) % 10);
    return r;
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    int t;
    logic [7:0] r;
    t = (v > 99) ? 99 : v;
    r[3:0] = 4'(t % 10);
    r[7:4] = 4'((t / 10) % 10);
    return r;
  endfunction

  // Launch one bullet and check every cycle against the flight model:
  // ticks every TICK cycles after launch, y = Y0 - STEP*ticks, slot i of
  // tick m strobes kill at cycle TICK*m + i + 1, off-top retire at tick 111.
  task automatic run_flight(input int bx, input int mx0, input int my0, input int mx1,
                            input int my1, input logic [1:0] alive, input bit hold,
                            input bit retrig, input string tag);
    int mx[2];
    int my[2];
    int m_hit, i_hit, end_k, exp_y, pre, y, tout;
    logic [1:0] exp_kill;
    bit exp_act;
    mx[0] = mx0; my[0] = my0; mx[1] = mx1; my[1] = my1;
    m_hit = 0; i_hit = -1;
    for (int m = 1; m <= 110; m++) begin
      y = Y0 - STEP * m;
      for (int i = 0; i < 2; i++)
        if (i_hit < 0 && alive[i] && mx[i] <= bx && bx < mx[i] + MOSQ_SIZE &&
            my[i] <= y && y < my[i] + MOSQ_SIZE) begin
          m_hit = m; i_hit = i;
        end
    end
    end_k = (i_hit >= 0) ? TICK * m_hit + i_hit + 1 : TICK * 111;
    pre = hits_total;
    if (i_hit >= 0) hits_total++;

    @(negedge clk25);
    bus.player_x            = 10'(bx);
    bus.mosquito_x_flat     = {10'(mx1), 10'(mx0)};
    bus.mosquito_y_flat     = {10'(my1), 10'(my0)};
    bus.mosquito_alive_flat = alive;
    bus.fire                = 1'b1;
    for (int k = 0; k <= end_k + 4; k++) begin
      @(negedge clk25);
      exp_act  = (k < end_k) ? 1'b1 : ((k == end_k) ? 1'b0 : (AUTO && hold));
      exp_kill = (k == end_k && i_hit >= 0) ? (2'b01 << i_hit) : 2'b00;
      checks++;
      if (bus.bullet_active !== exp_act) begin
        errors++;
        $display("FAIL %s active k=%0d got %0b want %0b", tag, k, bus.bullet_active, exp_act);
      end
      checks++;
      if (bus.kill_flat !== exp_kill || bus2.kill_flat !== exp_kill) begin
        errors++;
        $display("FAIL %s kill k=%0d got %b/%b want %b", tag, k, bus.kill_flat, bus2.kill_flat, exp_kill);
      end
      checks++;
      if (bus.hit_pulse !== (exp_kill != 2'b00)) begin
        errors++;
        $display("FAIL %s hit_pulse k=%0d got %0b want %0b", tag, k, bus.hit_pulse, exp_kill != 2'b00);
      end
      if (k <= end_k) begin
        exp_y = Y0 - STEP * (((k / TICK) > 110) ? 110 : (k / TICK));
        checks++;
        if (bus.bullet_y !== 10'(exp_y) || bus.bullet_x !== 10'(bx)) begin
          errors++;
          $display("FAIL %s pos k=%0d got (%0d,%0d) want (%0d,%0d)", tag, k,
                   bus.bullet_x, bus.bullet_y, bx, exp_y);
        end
      end
      if (k == 0) begin
        checks++;
        if (bus.score_bcd !== to_bcd4(pre)) begin
          errors++;
          $display("FAIL %s score_pre got %h want %h", tag, bus.score_bcd, to_bcd4(pre));
        end
      end
      if (k == end_k) begin
        checks++;
        if (bus.score_bcd !== to_bcd4(hits_total) || bus2.score_bcd !== to_bcd2(hits_total)) begin
          errors++;
          $display("FAIL %s score got %h/%h want %h/%h", tag, bus.score_bcd, bus2.score_bcd,
                   to_bcd4(hits_total), to_bcd2(hits_total));
        end
      end
      bus.fire = hold || (retrig && k >= 100 && k < 104);
    end
    bus.fire = 1'b0;
    tout = 0;
    while (bus.bullet_active && tout < 1000) begin
      @(negedge clk25);
      tout++;
    end
    checks++;
    if (bus.bullet_active !== 1'b0) begin
      errors++;
      $display("FAIL %s settle timeout got active=%0b want 0", tag, bus.bullet_active);
    end
    @(negedge clk25);
  endtask

  task automatic test_reset();
    bus.fire = 1'b0; bus.player_x = '0; bus.mosquito_x_flat = '0;
    bus.mosquito_y_flat = '0; bus.mosquito_alive_flat = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk25);
    checks++;
    if (bus.bullet_active !== 1'b0 || bus.bullet_x !== 10'd0 || bus.bullet_y !== 10'd440 ||
        bus.kill_flat !== 2'b00 || bus.hit_pulse !== 1'b0 || bus.score_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values got act=%0b x=%0d y=%0d kill=%b hit=%0b score=%h",
               bus.bullet_active, bus.bullet_x, bus.bullet_y, bus.kill_flat, bus.hit_pulse, bus.score_bcd);
    end
    reset_n = 1'b1;
    @(negedge clk25);
    run_flight(300, 296, 400, 0, 0, 2'b01, 1'b0, 1'b0, "pre_reset_hit");
    bus.mosquito_alive_flat = 2'b00;
    bus.fire = 1'b1;
    @(negedge clk25);
    bus.fire = 1'b0;
    repeat (20) @(negedge clk25);
    checks++;
    if (bus.bullet_active !== 1'b1 || bus.score_bcd !== 16'h0001) begin
      errors++;
      $display("FAIL reset_preflight got act=%0b score=%h want 1 0001", bus.bullet_active, bus.score_bcd);
    end
    @(posedge clk25);
    #5 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.bullet_active !== 1'b0 || bus.bullet_y !== 10'd440 || bus.score_bcd !== 16'h0000 ||
        bus2.score_bcd !== 8'h00 || bus.kill_flat !== 2'b00) begin
      errors++;
      $display("FAIL reset_async got act=%0b y=%0d score=%h kill=%b want 0 440 0000 00",
               bus.bullet_active, bus.bullet_y, bus.score_bcd, bus.kill_flat);
    end
    hits_total = 0;
    @(negedge clk25);
    reset_n = 1'b1;
    @(negedge clk25);
  endtask

  task automatic test_miss();
    run_flight(300, 296, 400, 296, 400, 2'b00, 1'b0, 1'b0, "miss");
  endtask

  task automatic test_hit_slot1();
    run_flight(300, 0, 0, 296, 400, 2'b10, 1'b0, 1'b0, "hit_slot1");
  endtask

  task automatic test_overlap();
    run_flight(300, 296, 400, 296, 400, 2'b11, 1'b0, 1'b0, "overlap");
  endtask

  task automatic test_boundary();
    run_flight(1023, 1015, 300, 0, 0, 2'b01, 1'b0, 1'b0, "x_top_edge");
    run_flight(216, 200, 300, 201, 300, 2'b11, 1'b0, 1'b0, "x_right_edge");
  endtask

  task automatic test_fire_while_active();
    run_flight(300, 0, 0, 0, 0, 2'b00, 1'b0, 1'b1, "retrig");
    run_flight(120, 0, 0, 0, 0, 2'b00, 1'b1, 1'b0, "hold");
  endtask

  task automatic test_random();
    int bx, r, mx0, mx1, my0, my1;
    logic [1:0] alive;
    for (int n = 0; n < 20; n++) begin
      bx = $urandom_range(0, 1023);
      r = $urandom_range(0, 15); mx0 = (bx - r < 0) ? 0 : bx - r;
      r = $urandom_range(0, 15); mx1 = (bx - r < 0) ? 0 : bx - r;
      if ($urandom_range(0, 3) == 0) mx0 = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) mx1 = $urandom_range(0, 1023);
      my0 = $urandom_range(0, 479);
      my1 = $urandom_range(0, 479);
      alive = 2'($urandom_range(0, 3));
      run_flight(bx, mx0, my0, mx1, my1, alive, 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_saturation();
    while (hits_total < 101)
      run_flight(100, 90, 424, 0, 0, 2'b01, 1'b0, 1'b0, "saturate");
    checks++;
    if (bus2.score_bcd !== 8'h99) begin
      errors++;
      $display("FAIL saturate_hold got %h want 99", bus2.score_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit_slot1();
    test_overlap();
    test_boundary();
    test_fire_while_active();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
